// File: rtl/bip_dbg_ctrl.sv
// bip_dbg_ctrl -- UART command controller for the BIP CPU.
//
// Decodes one-byte commands from the UART receiver and drives the CPU
// clock enable and soft reset. It snapshots acc/pc/halt and the cycle
// counter into a 7-byte report, or sends a single-byte ACK/ERR reply.
//
// Ports:
//   i_clk, i_reset       system clock, synchronous active-high reset
//   i_rx_data/i_rx_done  received byte + one-cycle strobe
//   o_tx_data/o_tx_start byte to send + one-cycle start pulse
//   i_tx_done            one-cycle strobe, TX byte finished
//   i_cpu_halt           CPU executed HLT (level)
//   i_acc, i_pc          CPU architectural state for the report
//   o_cpu_en, o_cpu_rst  CPU clock enable and soft reset
//   o_busy               high whenever the controller is not idle
//
// Commands: 0x01 RUN, 0x02 STEP, 0x03 CPU reset, 0x04 READ, other -> ERR_BYTE.
module bip_dbg_ctrl #(
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF,
  parameter logic [7:0]  ACK_BYTE   = 8'hA5,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_done,
  input  logic        i_tx_done,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  input  logic        i_cpu_halt,
  input  logic [15:0] i_acc,
  input  logic [10:0] i_pc,
  output logic        o_cpu_en,
  output logic        o_cpu_rst,
  output logic        o_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_CRST   = 3'd4;
  localparam logic [2:0] S_SNAP   = 3'd5;
  localparam logic [2:0] S_TXS    = 3'd6;
  localparam logic [2:0] S_TXW    = 3'd7;

  localparam logic [7:0] C_RUN  = 8'h01;
  localparam logic [7:0] C_STEP = 8'h02;
  localparam logic [7:0] C_CRST = 8'h03;
  localparam logic [7:0] C_READ = 8'h04;

  logic [2:0]      r_state, w_nxt;
  logic [15:0]     r_run_cnt, r_cyc;
  logic            r_tmo, r_crst_ph;
  logic [2:0]      r_idx, r_len;
  logic [6:0][7:0] r_frame;
  logic [7:0]      r_tx_data;
  logic            r_tx_start, r_cpu_en, r_cpu_rst, r_busy;

  logic [15:0] w_run_base;
  logic        w_run_en, w_cmd, w_en_issue, w_last;
  logic [2:0]  w_idx_nxt;

  // o_cpu_en is registered, so the enable for the next cycle is decided one
  // cycle early. The run counter therefore counts enables already issued;
  // on RUN entry (still in IDLE) it counts from zero.
  assign w_run_base = (r_state == S_IDLE) ? 16'd0 : r_run_cnt;
  assign w_run_en   = !i_cpu_halt && (w_run_base < MAX_CYCLES);
  assign w_cmd      = i_rx_done && (r_state == S_IDLE);
  assign w_en_issue = (w_cmd && ((i_rx_data == C_RUN  && w_run_en) ||
                                 (i_rx_data == C_STEP && !i_cpu_halt))) ||
                      (r_state == S_RUN && w_run_en);
  assign w_idx_nxt  = r_idx + 3'd1;
  assign w_last     = (r_idx == r_len - 3'd1);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (i_rx_done) begin
          case (i_rx_data)
            C_RUN:   w_nxt = S_RUN;
            C_STEP:  w_nxt = S_STEP;
            C_CRST:  w_nxt = S_CRST;
            C_READ:  w_nxt = S_SNAP;
            default: w_nxt = S_TXS;
          endcase
        end
      S_RUN:    if (!w_run_en) w_nxt = S_SNAP;
      S_STEP:   w_nxt = S_SETTLE;
      S_SETTLE: w_nxt = S_SNAP;
      S_CRST:   if (r_crst_ph) w_nxt = S_TXS;
      S_SNAP:   w_nxt = S_TXS;
      S_TXS:    w_nxt = S_TXW;
      S_TXW:    if (i_tx_done) w_nxt = w_last ? S_IDLE : S_TXS;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_run_cnt  <= '0;
      r_cyc      <= '0;
      r_tmo      <= 1'b0;
      r_crst_ph  <= 1'b0;
      r_idx      <= '0;
      r_len      <= '0;
      r_frame    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_cpu_en   <= 1'b0;
      r_cpu_rst  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_busy     <= (w_nxt != S_IDLE);
      r_tx_start <= 1'b0;
      r_cpu_en   <= 1'b0;
      r_cpu_rst  <= 1'b0;

      // saturating cycle counter, one count per enable issued
      if (w_en_issue && r_cyc != 16'hFFFF) r_cyc <= r_cyc + 16'd1;

      case (r_state)
        S_IDLE:
          if (i_rx_done) begin
            case (i_rx_data)
              C_RUN: begin
                r_tmo     <= 1'b0;
                r_cpu_en  <= w_run_en;
                r_run_cnt <= {15'd0, w_run_en};
              end
              C_STEP: begin
                r_tmo    <= 1'b0;
                r_cpu_en <= !i_cpu_halt;
              end
              C_CRST: begin
                r_cpu_rst <= 1'b1;
                r_crst_ph <= 1'b0;
                r_cyc     <= '0;
              end
              C_READ: r_tmo <= 1'b0;
              default: begin
                r_tx_data  <= ERR_BYTE;
                r_tx_start <= 1'b1;
                r_len      <= 3'd1;
                r_idx      <= '0;
              end
            endcase
          end
        S_RUN: begin
          r_cpu_en <= w_run_en;
          if (w_run_en)         r_run_cnt <= r_run_cnt + 16'd1;
          else if (!i_cpu_halt) r_tmo     <= 1'b1;  // halt wins over timeout
        end
        S_CRST: begin
          r_crst_ph <= 1'b1;
          if (!r_crst_ph) begin
            r_cpu_rst <= 1'b1;  // second of the two reset cycles
          end else begin
            r_tx_data  <= ACK_BYTE;
            r_tx_start <= 1'b1;
            r_len      <= 3'd1;
            r_idx      <= '0;
          end
        end
        S_SNAP: begin
          // r_frame[0] is the first byte on the wire
          r_frame    <= {r_cyc[7:0], r_cyc[15:8], i_pc[7:0], {5'd0, i_pc[10:8]},
                         i_acc[7:0], i_acc[15:8], {i_cpu_halt, r_tmo, 6'd0}};
          r_tx_data  <= {i_cpu_halt, r_tmo, 6'd0};
          r_tx_start <= 1'b1;
          r_len      <= 3'd7;
          r_idx      <= '0;
        end
        S_TXW:
          if (i_tx_done && !w_last) begin
            r_idx      <= w_idx_nxt;
            r_tx_data  <= r_frame[w_idx_nxt];
            r_tx_start <= 1'b1;
          end
        default: ;
      endcase
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_cpu_en   = r_cpu_en;
  assign o_cpu_rst  = r_cpu_rst;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_bip_dbg_ctrl.sv
// Bench for bip_dbg_ctrl: two instances (default MAX_CYCLES and MAX_CYCLES=10),
// a small CPU model on instance 1 whose HLT is the 5th instruction (halt is
// visible while that instruction is presented), and a UART TX model.
module tb_bip_dbg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rx_done, tx_done, sel;
  logic [7:0]  rx_data;
  logic [15:0] acc;
  logic [10:0] pc;

  logic [7:0] tx_data1, tx_data2;
  logic       tx_start1, tx_start2, en1, en2, crst1, crst2, busy1, busy2;
  logic       halt1;
  int         cpu_cnt = 0;
  int         halt_lim = 4;

  assign halt1 = (cpu_cnt >= halt_lim);
  always @(posedge clk)
    if (rst || crst1) cpu_cnt <= 0;
    else if (en1)     cpu_cnt <= cpu_cnt + 1;

  bip_dbg_ctrl u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done & !sel),
    .i_tx_done(tx_done & !sel), .o_tx_data(tx_data1), .o_tx_start(tx_start1),
    .i_cpu_halt(halt1), .i_acc(acc), .i_pc(pc), .o_cpu_en(en1),
    .o_cpu_rst(crst1), .o_busy(busy1));

  bip_dbg_ctrl #(.MAX_CYCLES(16'd10)) u_dut2 (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done & sel),
    .i_tx_done(tx_done & sel), .o_tx_data(tx_data2), .o_tx_start(tx_start2),
    .i_cpu_halt(1'b0), .i_acc(acc), .i_pc(pc), .o_cpu_en(en2),
    .o_cpu_rst(crst2), .o_busy(busy2));

  logic [7:0] w_tx_data;
  logic       w_tx_start, w_en, w_crst, w_busy;
  assign w_tx_data  = sel ? tx_data2  : tx_data1;
  assign w_tx_start = sel ? tx_start2 : tx_start1;
  assign w_en       = sel ? en2       : en1;
  assign w_crst     = sel ? crst2     : crst1;
  assign w_busy     = sel ? busy2     : busy1;

  // running totals sampled mid-cycle
  int en_tot = 0, rst_tot = 0, st_tot = 0;
  always @(negedge clk) begin
    if (w_en)       en_tot  <= en_tot + 1;
    if (w_crst)     rst_tot <= rst_tot + 1;
    if (w_tx_start) st_tot  <= st_tot + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  typedef struct packed {
    logic        sel;
    logic [7:0]  cmd;
    logic [15:0] acc;
    logic [10:0] pc;
    logic [3:0]  len;
    logic [55:0] frame;  // byte 0 in the top byte
    logic [7:0]  en;
    logic [7:0]  rst;
    logic [7:0]  lat;    // cycles from command to first tx_start, 0 = unchecked
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [7:0] c, input logic [15:0] a,
                              input logic [10:0] p, input logic [3:0] l,
                              input logic [55:0] f, input logic [7:0] e,
                              input logic [7:0] r, input logic [7:0] lt);
    vec_t v;
    v.sel = s; v.cmd = c; v.acc = a; v.pc = p; v.len = l;
    v.frame = f; v.en = e; v.rst = r; v.lat = lt;
    return v;
  endfunction

  // send one command, play the TX side, collect the reply, compare
  task automatic apply(input vec_t v);
    logic [55:0] got;
    logic [7:0]  b;
    int n, cyc, lat, en0, rs0;
    bit hs_ok, done;
    string tag;
    got = '0; n = 0; cyc = 0; lat = 0; hs_ok = 1; done = 0;
    tag = $sformatf("cmd%02h/dut%0d", v.cmd, v.sel + 1);
    sel = v.sel; acc = v.acc; pc = v.pc;
    en0 = en_tot; rs0 = rst_tot;
    rx_data = v.cmd; rx_done = 1'b1; tick(); rx_done = 1'b0; cyc = 1;
    while (!done && cyc < 400) begin
      if (w_tx_start) begin
        if (n < 7) got[55 - 8*n -: 8] = w_tx_data;
        if (n == 0) lat = cyc;
        n++;
        b = w_tx_data;
        repeat (2) begin
          tick(); cyc++;
          if (w_tx_start || w_tx_data !== b) hs_ok = 0;  // one pulse, data held
        end
        tx_done = 1'b1; tick(); tx_done = 1'b0; cyc++;
        if (!w_busy) done = 1;
        else if (!w_tx_start) hs_ok = 0;                // next start 1 cycle after done
      end else begin
        tick(); cyc++;
      end
    end
    chk({tag, " finished"}, done, 1);
    chk({tag, " len"}, n, v.len);
    chk({tag, " frame"}, got, v.frame);
    chk({tag, " en_cycles"}, en_tot - en0, v.en);
    chk({tag, " rst_cycles"}, rst_tot - rs0, v.rst);
    if (v.lat != 0) chk({tag, " latency"}, lat, v.lat);
    chk({tag, " tx_handshake"}, hs_ok, 1);
  endtask

  task automatic wait_start(input string nm);
    int k;
    k = 0;
    while (!w_tx_start && k < 50) begin tick(); k++; end
    chk({nm, " tx_start_seen"}, w_tx_start, 1);
  endtask

  vec_t tbl[12];

  initial begin
    int s0;
    rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; sel = 1'b0;
    rx_data = '0; acc = '0; pc = '0;

    tbl[0]  = mk(0, 8'h04, 16'h1234, 11'h456, 7, 56'h00_12_34_04_56_00_00, 0, 0, 2);
    tbl[1]  = mk(0, 8'h01, 16'h00FF, 11'h123, 7, 56'h80_00_FF_01_23_00_05, 5, 0, 7);
    tbl[2]  = mk(0, 8'h7F, 16'h00FF, 11'h123, 1, {8'hEE, 48'h0},           0, 0, 1);
    tbl[3]  = mk(0, 8'h02, 16'h00FF, 11'h123, 7, 56'h80_00_FF_01_23_00_05, 0, 0, 4);
    tbl[4]  = mk(0, 8'h03, 16'h00FF, 11'h123, 1, {8'hA5, 48'h0},           0, 2, 3);
    tbl[5]  = mk(0, 8'h02, 16'hBEEF, 11'h7FF, 7, 56'h00_BE_EF_07_FF_00_01, 1, 0, 4);
    tbl[6]  = mk(0, 8'h02, 16'hBEEF, 11'h7FF, 7, 56'h00_BE_EF_07_FF_00_02, 1, 0, 4);
    tbl[7]  = mk(0, 8'h02, 16'hBEEF, 11'h7FF, 7, 56'h00_BE_EF_07_FF_00_03, 1, 0, 4);
    tbl[8]  = mk(0, 8'h03, 16'hBEEF, 11'h7FF, 1, {8'hA5, 48'h0},           0, 2, 3);
    tbl[9]  = mk(0, 8'h04, 16'hBEEF, 11'h7FF, 7, 56'h00_BE_EF_07_FF_00_00, 0, 0, 2);
    tbl[10] = mk(1, 8'h01, 16'h00FF, 11'h123, 7, 56'h40_00_FF_01_23_00_0A, 10, 0, 12);
    tbl[11] = mk(1, 8'h04, 16'h00FF, 11'h123, 7, 56'h00_00_FF_01_23_00_0A, 0, 0, 2);

    tick(); tick();
    chk("reset_outputs_dut1", {tx_data1, tx_start1, en1, crst1, busy1}, 0);
    chk("reset_outputs_dut2", {tx_data2, tx_start2, en2, crst2, busy2}, 0);
    rst = 1'b0; tick();

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i]);
      repeat (2) tick();
    end

    // bytes arriving during TX_WAIT, and together with the final tx_done, are dropped
    sel = 1'b0; s0 = st_tot;
    rx_data = 8'h7F; rx_done = 1'b1; tick(); rx_done = 1'b0;
    wait_start("drop");
    tick();
    rx_data = 8'h04; rx_done = 1'b1; tick(); rx_done = 1'b0;
    tick();
    rx_data = 8'h04; rx_done = 1'b1; tx_done = 1'b1; tick(); rx_done = 1'b0; tx_done = 1'b0;
    chk("drop busy_after_reply", w_busy, 0);
    repeat (30) tick();
    chk("drop tx_starts_total", st_tot - s0, 1);
    chk("drop busy_stays_low", w_busy, 0);

    // reset in the middle of a long RUN
    halt_lim = 1000;
    rx_data = 8'h01; rx_done = 1'b1; tick(); rx_done = 1'b0;
    repeat (5) tick();
    chk("midrun en_active", en1, 1);
    rst = 1'b1; tick();
    chk("midrun reset_outputs", {tx_data1, tx_start1, en1, crst1, busy1}, 0);
    rst = 1'b0; halt_lim = 4; tick();

    // reset in the middle of a frame, then a clean READ
    acc = 16'h0F0F; pc = 11'h2A5;
    rx_data = 8'h04; rx_done = 1'b1; tick(); rx_done = 1'b0;
    repeat (2) begin
      wait_start("midframe");
      tick();
      tx_done = 1'b1; tick(); tx_done = 1'b0;
    end
    rst = 1'b1; tick();
    chk("midframe reset_outputs", {tx_data1, tx_start1, en1, crst1, busy1}, 0);
    rst = 1'b0; tick();
    repeat (3) tick();
    chk("midframe no_resume", tx_start1 | busy1, 0);
    apply(mk(0, 8'h04, 16'h0F0F, 11'h2A5, 7, 56'h00_0F_0F_02_A5_00_00, 0, 0, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bip_dbg_ctrl.md
# bip_dbg_ctrl

UART-driven run/step controller and result reporter for the BIP CPU. It decodes single-byte commands from the UART receiver and sequences the CPU through a clock-enable and a soft reset. It snapshots the CPU's architectural state and returns it as a fixed 7-byte report frame through the UART transmitter. It sits between the UART RX/TX pair and `cpu_top`; the CPU runs on `i_clk` gated only by `o_cpu_en`, with no derived clock.

## Interface
- `MAX_CYCLES`, default 16'hFFFF: RUN timeout, in enabled CPU cycles per RUN command.
- `ACK_BYTE`, default 8'hA5: reply to the CPU-reset command.
- `ERR_BYTE`, default 8'hEE: reply to an unknown command.
- `i_clk`  in  1  system clock.
- `i_reset`  in  1  reset, synchronous, active-high.
- `i_rx_data`  in  8  received byte; valid when `i_rx_done`.
- `i_rx_done`  in  1  one-cycle pulse, byte received.
- `i_tx_done`  in  1  one-cycle pulse, TX byte finished.
- `o_tx_data`  out  8  byte to transmit.
- `o_tx_start`  out  1  one-cycle pulse, start TX of `o_tx_data`.
- `i_cpu_halt`  in  1  CPU has executed HLT (level).
- `i_acc`  in  16  CPU accumulator.
- `i_pc`  in  11  CPU program counter.
- `o_cpu_en`  out  1  CPU clock enable; the CPU advances one instruction per high cycle.
- `o_cpu_rst`  out  1  CPU soft reset.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- Commands, accepted only in IDLE when `i_rx_done`=1:
  - 0x01 RUN: go to RUN.
  - 0x02 STEP: go to STEP.
  - 0x03 CRST: go to CRST.
  - 0x04 READ: go to SNAP.
  - Any other byte: load `ERR_BYTE` into the single-byte TX path.
- Bytes arriving while not in IDLE are dropped silently.
- RUN:
  - On entry, the run counter is cleared.
  - Each cycle with `i_cpu_halt`=0 and run counter < `MAX_CYCLES`: `o_cpu_en`=1, run counter +1, cycle counter +1.
  - `i_cpu_halt`=1: go to SNAP with timeout flag = 0.
  - Run counter = `MAX_CYCLES`: go to SNAP with timeout flag = 1.
  - If the CPU is already halted at entry, no enable pulses are issued.
- STEP:
  - If `i_cpu_halt`=0: `o_cpu_en`=1 for exactly one cycle and cycle counter +1.
  - Then SETTLE (1 cycle), then SNAP.
  - If halted, skip the enable and go to SETTLE.
- CRST:
  - `o_cpu_rst`=1 for 2 cycles.
  - Cycle counter cleared to 0.
  - Then transmit `ACK_BYTE`.
- SNAP: capture a 7-byte frame in one cycle:
  - byte 0: {halt, timeout, 6'b0}
  - byte 1: acc[15:8]
  - byte 2: acc[7:0]
  - byte 3: {5'b0, pc[10:8]}
  - byte 4: pc[7:0]
  - byte 5: cyc[15:8]
  - byte 6: cyc[7:0]
- TX_START / TX_WAIT:
  - TX_START pulses `o_tx_start` and moves to TX_WAIT.
  - TX_WAIT holds `o_tx_data` stable until `i_tx_done`, then the byte index increments.
  - After the last byte, return to IDLE.
  - Single-byte replies (ACK, ERR) have length 1.
- Cycle counter: 16 bits, saturating at 16'hFFFF; it never wraps. It is cleared only by `i_reset` or CRST.
- Timeout flag: cleared on every RUN/STEP/READ entry.

## Timing
- All outputs are registered. Reset values:
  - `o_tx_data`=0
  - `o_tx_start`=0
  - `o_cpu_en`=0
  - `o_cpu_rst`=0
  - `o_busy`=0
  - state=IDLE, counters=0, flags=0
- `i_reset` mid-operation aborts any run or transmission immediately. A partially sent frame is not resumed.
- READ latency: with `i_rx_done` in cycle N, SNAP occurs in N+1 and `o_tx_start`=1 in cycle N+2.
- RUN: the first `o_cpu_en` occurs in cycle N+1. `o_cpu_en` drops in the cycle after `i_cpu_halt` is sampled high.
- Back-to-back bytes: the next `o_tx_start` is asserted exactly 1 cycle after each `i_tx_done`.
- `i_tx_done` outside TX_WAIT is ignored.
- `i_rx_done` in the same cycle the FSM returns to IDLE is dropped; acceptance starts the cycle after entering IDLE.

## Test plan
- READ after reset, with acc=16'h1234, pc=11'h456, halt=0 -> frame 00 12 34 04 56 00 00; `o_busy` low after the 7th `i_tx_done`.
- RUN, with CPU model halting after 5 enables, acc=16'h00FF -> exactly 5 `o_cpu_en` cycles, then frame 80 00 FF .. .. 00 05.
- RUN with `MAX_CYCLES`=10 and a never-halting CPU -> 10 enables, then status byte 40, cyc=000A.
- STEP ×3, then CRST, then READ -> three single enable pulses; reply A5 with 2-cycle `o_cpu_rst`; READ shows cyc=0000.
- Byte 0x7F -> single reply EE. A byte sent during TX_WAIT is dropped and never answered.
- `i_reset` asserted mid-RUN and mid-frame -> all outputs 0 next cycle; a subsequent READ returns a fresh full 7-byte frame.
